pc_run_ctrl: RTL and testbench
==============================

Name: pc_run_ctrl

Overview:
Run/halt/single-step controller that sequences the program counter register through its `control` write-enable input.
- Produces the PC advance enable each cycle, honouring memory stalls, decoded halt instructions and operator go/step buttons.
- Keeps retired-instruction and active-cycle counters for the board display.
- Sits between the front-panel inputs, the decoder's halt flag and the PC register.

Parameters:
PC_W, 32, width of the PC value compared for breakpoints
CNT_W, 32, width of instr_cnt and cycle_cnt
STARTUP_CYCLES, 2, cycles held in INIT after reset release (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
go  in  1  run button, synchronous level; the block acts on its rising edge
step  in  1  single-step button, synchronous level; the block acts on its rising edge
halt_req  in  1  decoder flag: current instruction is HALT
stall  in  1  memory not ready; PC must not advance
cnt_clr  in  1  synchronous clear of both counters
pc  in  PC_W  current PC value
bp_addr  in  PC_W  breakpoint address to load
bp_set  in  1  load bp_addr, arm breakpoint
bp_clr  in  1  disarm breakpoint
pc_en  out  1  PC advance enable, drives PC control
state  out  2  00 INIT, 01 RUN, 10 HALT, 11 STEP
halted  out  1  state==HALT
bp_hit  out  1  sticky: last halt caused by breakpoint
instr_cnt  out  CNT_W  instructions retired (pc_en cycles)
cycle_cnt  out  CNT_W  cycles spent in RUN or STEP

Behaviour:
- Reset (rst=0, async): state=INIT, startup counter=0, go/step edge registers=0, counters=0, bp_hit=0, breakpoint disarmed, pc_en=0.
- Edge detect: go_e = go & ~go_q; step_e = step & ~step_q; go_q/step_q are registered every cycle.
- INIT: pc_en=0; after STARTUP_CYCLES cycles, go to HALT. Edges during INIT are discarded.
- HALT: pc_en=0.
  - go_e → RUN; bp_hit cleared; skip flag set.
  - step_e without go_e → STEP; bp_hit cleared; skip flag set.
  - go_e and step_e together: go wins.
- RUN:
  - stop = halt_req | bp_match.
  - pc_en = ~stall & ~stop (combinational).
  - stop=1 → HALT next cycle; pc_en=0 that cycle, so the PC holds the halting instruction's address.
  - step_e in RUN → HALT next cycle (pause); the current cycle's pc_en is unaffected.
  - go_e in RUN is ignored.
- STEP:
  - pc_en = ~stall & ~stop.
  - Stays in STEP while stall=1.
  - Returns to HALT the cycle after pc_en=1, or immediately when stop=1.
  - Edges in STEP are ignored.
- stall and halt_req together: stop dominates; go to HALT.
- halt_req is sampled only in RUN/STEP.
- Counters:
  - instr_cnt += 1 on each pc_en cycle.
  - cycle_cnt += 1 on each RUN/STEP cycle.
  - Both saturate at all-ones (no wrap).
  - cnt_clr has priority over increment.
- skip flag: cleared on the first cycle with pc_en=1. While set, bp_match is forced 0, so resuming from a breakpoint address does not re-trigger immediately.
- Reset mid-run: immediate return to INIT with pc_en=0; the PC register's own reset is independent.

Optional Feature:
BREAKPOINT_EN
- Defined:
  - bp_set loads bp_addr into bp_reg and arms it. bp_clr disarms. bp_clr wins if both are asserted.
  - bp_match = armed & ~skip & (pc == bp_reg) & state in {RUN, STEP}.
  - A match sets bp_hit on the transition to HALT.
- Undefined: bp_reg is absent; bp_match=0 and bp_hit=0 constantly. bp_addr, bp_set and bp_clr remain as ports and are ignored.

Test Plan:
- Release rst with STARTUP_CYCLES=2 → state 00 for 2 cycles, then 10; pc_en=0 throughout; counters 0.
- HALT, pulse go, stall=0 for 5 cycles, then halt_req=1 → pc_en=1 for 5 cycles; pc_en=0 on the halt_req cycle; state=10 next cycle; instr_cnt=5, cycle_cnt=6.
- HALT, step_e with stall=1 for 3 cycles then 0 → state=11 for 4 cycles; pc_en=1 exactly once (4th cycle); instr_cnt += 1; back to 10.
- go and step rising on the same HALT cycle → state=01; go held high for 10 cycles produces no second edge effect.
- BREAKPOINT_EN defined, bp_reg=0x40, RUN reaches pc=0x40 → pc_en=0, HALT, bp_hit=1; pulse go → pc_en=1 at 0x40, no re-hit, bp_hit=0.
- Counters preset near all-ones in RUN → saturate at all-ones; cnt_clr the same cycle → 0. rst=0 mid-RUN → pc_en=0 and state=00 asynchronously.

Source files
------------

// File: rtl/pc_run_ctrl.sv
// Run/halt/single-step sequencer producing the PC advance enable and display counters.
// Latency: pc_en is combinational from the current state and stall/halt/breakpoint inputs; state moves one cycle later.
// Backpressure: stall holds the PC (pc_en=0) without leaving RUN/STEP; halt_req/breakpoint dominate stall.
//
// Ports: clk/rst (async active-low); go/step front-panel levels (rising edge acted on);
//        halt_req from decoder; stall from memory; cnt_clr clears counters; pc/bp_addr/bp_set/bp_clr
//        breakpoint compare and load; outputs pc_en, state, halted, bp_hit, instr_cnt, cycle_cnt.
// Optional feature macro: BREAKPOINT_EN (PC breakpoint register and sticky bp_hit).
module pc_run_ctrl #(
    parameter int PC_W           = 32,
    parameter int CNT_W          = 32,
    parameter int STARTUP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             step,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             cnt_clr,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_set,
    input  logic             bp_clr,
    output logic             pc_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_STEP = 2'b11
    } state_e;

    localparam logic [3:0] SU_LAST = 4'(STARTUP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       su_cnt_q, su_cnt_d;
    logic             go_q, go_d;
    logic             step_q, step_d;
    logic             skip_q, skip_d;
    logic             bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic go_e, step_e, active, bp_match, stop, pc_en_c;

`ifdef BREAKPOINT_EN
    logic [PC_W-1:0] bp_reg_q, bp_reg_d;
    logic            bp_arm_q, bp_arm_d;

    always_comb begin
        bp_reg_d = bp_reg_q;
        bp_arm_d = bp_arm_q;
        if (bp_set) begin
            bp_reg_d = bp_addr;
            bp_arm_d = 1'b1;
        end
        // Disarm wins over a simultaneous load.
        if (bp_clr) begin
            bp_arm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_reg_q <= '0;
            bp_arm_q <= 1'b0;
        end else begin
            bp_reg_q <= bp_reg_d;
            bp_arm_q <= bp_arm_d;
        end
    end

    // Skip masks the compare right after resuming so a halt at the
    // breakpoint address can be left without re-triggering.
    assign bp_match = bp_arm_q & ~skip_q & (pc == bp_reg_q) & active;
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_set, bp_clr};
    assign bp_match  = 1'b0;
`endif

    always_comb begin
        go_d     = go;
        step_d   = step;
        go_e     = go & ~go_q;
        step_e   = step & ~step_q;
        active   = (state_q == ST_RUN) || (state_q == ST_STEP);
        stop     = active & (halt_req | bp_match);
        pc_en_c  = active & ~stall & ~stop;

        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        bp_hit_d = bp_hit_q;
        skip_d   = pc_en_c ? 1'b0 : skip_q;

        case (state_q)
            ST_INIT: begin
                // Button edges seen here are simply dropped.
                if (su_cnt_q == SU_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    su_cnt_d = su_cnt_q + 4'd1;
                end
            end
            ST_HALT: begin
                if (go_e) begin
                    state_d  = ST_RUN;
                    bp_hit_d = 1'b0;
                    skip_d   = 1'b1;
                end else if (step_e) begin
                    state_d  = ST_STEP;
                    bp_hit_d = 1'b0;
                    skip_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_HALT;
                    bp_hit_d = bp_match;
                end else if (step_e) begin
                    // Pause request; this cycle's advance still happens.
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (stop) begin
                    state_d  = ST_HALT;
                    bp_hit_d = bp_match;
                end else if (pc_en_c) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Counters saturate at all-ones; clear takes priority.
        instr_d = instr_q;
        cyc_d   = cyc_q;
        if (cnt_clr) begin
            instr_d = '0;
            cyc_d   = '0;
        end else begin
            if (pc_en_c && (instr_q != '1)) instr_d = instr_q + 1'b1;
            if (active  && (cyc_q   != '1)) cyc_d   = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            su_cnt_q <= 4'd0;
            go_q     <= 1'b0;
            step_q   <= 1'b0;
            skip_q   <= 1'b0;
            bp_hit_q <= 1'b0;
            instr_q  <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            su_cnt_q <= su_cnt_d;
            go_q     <= go_d;
            step_q   <= step_d;
            skip_q   <= skip_d;
            bp_hit_q <= bp_hit_d;
            instr_q  <= instr_d;
            cyc_q    <= cyc_d;
        end
    end

    assign pc_en     = pc_en_c;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign bp_hit    = bp_hit_q;
    assign instr_cnt = instr_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_pc_run_ctrl.sv
// Directed scoreboard bench for pc_run_ctrl (CNT_W=4 so saturation is reachable).
// Expectations are queued as each cycle's stimulus is driven and compared on the falling edge.
// Breakpoint expectations follow the BREAKPOINT_EN build of the design.
module tb_pc_run_ctrl;

    localparam int PC_W = 8;
    localparam int CNT_W = 4;
    localparam logic [1:0] S_INIT = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10, S_STEP = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go = 1'b0, step = 1'b0, halt_req = 1'b0, stall = 1'b0, cnt_clr = 1'b0;
    logic [PC_W-1:0]  pc = '0, bp_addr = '0;
    logic             bp_set = 1'b0, bp_clr = 1'b0;
    logic             pc_en, halted, bp_hit;
    logic [1:0]       state;
    logic [CNT_W-1:0] instr_cnt, cycle_cnt;

    pc_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .STARTUP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .go(go), .step(step), .halt_req(halt_req), .stall(stall),
        .cnt_clr(cnt_clr), .pc(pc), .bp_addr(bp_addr), .bp_set(bp_set), .bp_clr(bp_clr),
        .pc_en(pc_en), .state(state), .halted(halted), .bp_hit(bp_hit),
        .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       en;
        logic       hit;
        logic       cc;
        logic [3:0] ic;
        logic [3:0] yc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("pc_en", 32'(pc_en), 32'(e.en));
            check("halted", 32'(halted), 32'(e.st == S_HALT));
            check("bp_hit", 32'(bp_hit), 32'(e.hit));
            if (e.cc) begin
                check("instr_cnt", 32'(instr_cnt), 32'(e.ic));
                check("cycle_cnt", 32'(cycle_cnt), 32'(e.yc));
            end
        end
    end

    // Drive one cycle of stimulus (just after the rising edge) and queue what
    // the outputs must show during that cycle.
    task automatic tick(input logic g, input logic s, input logic h, input logic sl,
                        input logic clr, input logic [PC_W-1:0] p,
                        input logic [1:0] st, input logic en, input logic hit,
                        input logic cc, input logic [3:0] ic, input logic [3:0] yc);
        exp_t e;
        go = g; step = s; halt_req = h; stall = sl; cnt_clr = clr; pc = p;
        e.st = st; e.en = en; e.hit = hit; e.cc = cc; e.ic = ic; e.yc = yc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held
        @(posedge clk); @(posedge clk); #1;
        check("rst_state", 32'(state), 32'(S_INIT));
        check("rst_pc_en", 32'(pc_en), 0);
        check("rst_instr", 32'(instr_cnt), 0);
        check("rst_cycle", 32'(cycle_cnt), 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        rst = 1'b1;

        // Startup: two INIT cycles, a go edge during INIT must be dropped.
        tick(0,0,0,0,0,8'h00, S_INIT,0,0, 1,0,0);
        tick(1,0,0,0,0,8'h00, S_INIT,0,0, 1,0,0);
        tick(1,0,0,0,0,8'h00, S_HALT,0,0, 1,0,0);
        tick(0,0,0,0,0,8'h00, S_HALT,0,0, 1,0,0);

        // Run five instructions, then a HALT instruction.
        tick(1,0,0,0,0,8'h00, S_HALT,0,0, 0,0,0);
        for (int k = 0; k < 5; k++)
            tick(0,0,0,0,0,8'(k), S_RUN,1,0, 1,4'(k),4'(k));
        tick(0,0,1,0,0,8'h05, S_RUN,0,0, 1,5,5);
        tick(0,0,0,0,0,8'h05, S_HALT,0,0, 1,5,6);

        // Single step through three stall cycles.
        tick(0,1,0,1,0,8'h05, S_HALT,0,0, 1,5,6);
        for (int k = 0; k < 3; k++)
            tick(0,1,0,1,0,8'h05, S_STEP,0,0, 1,5,4'(6+k));
        tick(0,1,0,0,0,8'h05, S_STEP,1,0, 1,5,9);
        tick(0,1,0,0,0,8'h06, S_HALT,0,0, 1,6,10);
        tick(0,0,0,0,0,8'h06, S_HALT,0,0, 1,6,10);

        // go and step together: go wins; go held high, counters saturate.
        tick(1,1,0,0,0,8'h06, S_HALT,0,0, 1,6,10);
        for (int k = 1; k <= 10; k++)
            tick(1,0,0,0,0,8'(6+k), S_RUN,1,0, 1,
                 4'((5+k) > 15 ? 15 : 5+k), 4'((9+k) > 15 ? 15 : 9+k));
        tick(1,0,0,0,1,8'h11, S_RUN,1,0, 1,15,15);
        tick(0,0,0,1,0,8'h12, S_RUN,0,0, 1,0,0);
        tick(0,0,1,1,0,8'h12, S_RUN,0,0, 1,0,1);
        tick(0,0,0,0,0,8'h12, S_HALT,0,0, 1,0,2);

        // Step edge in RUN pauses after the current advance.
        tick(1,0,0,0,0,8'h12, S_HALT,0,0, 0,0,0);
        tick(0,0,0,0,0,8'h12, S_RUN,1,0, 0,0,0);
        tick(0,1,0,0,0,8'h13, S_RUN,1,0, 0,0,0);
        tick(0,1,0,0,0,8'h14, S_HALT,0,0, 0,0,0);
        tick(0,0,0,0,0,8'h14, S_HALT,0,0, 0,0,0);

        // Breakpoint at 0x40.
        bp_addr = 8'h40; bp_set = 1'b1;
        tick(0,0,0,0,0,8'h3e, S_HALT,0,0, 0,0,0);
        bp_set = 1'b0;
        tick(1,0,0,0,0,8'h3e, S_HALT,0,0, 0,0,0);
        tick(0,0,0,0,0,8'h3e, S_RUN,1,0, 0,0,0);
        tick(0,0,0,0,0,8'h3f, S_RUN,1,0, 0,0,0);
`ifdef BREAKPOINT_EN
        tick(0,0,0,0,0,8'h40, S_RUN,0,0, 0,0,0);
        tick(1,0,0,0,0,8'h40, S_HALT,0,1, 0,0,0);
        tick(0,0,0,0,0,8'h40, S_RUN,1,0, 0,0,0);
        tick(0,0,0,0,0,8'h41, S_RUN,1,0, 0,0,0);
        tick(0,0,1,0,0,8'h42, S_RUN,0,0, 0,0,0);
        // Simultaneous set and clear leaves the breakpoint disarmed.
        bp_set = 1'b1; bp_clr = 1'b1;
        tick(0,0,0,0,0,8'h42, S_HALT,0,0, 0,0,0);
        bp_set = 1'b0; bp_clr = 1'b0;
        tick(1,0,0,0,0,8'h3f, S_HALT,0,0, 0,0,0);
        tick(0,0,0,0,0,8'h3f, S_RUN,1,0, 0,0,0);
        tick(0,0,0,0,0,8'h40, S_RUN,1,0, 0,0,0);
        tick(0,0,1,0,0,8'h41, S_RUN,0,0, 0,0,0);
        tick(0,0,0,0,0,8'h41, S_HALT,0,0, 0,0,0);
`else
        tick(0,0,0,0,0,8'h40, S_RUN,1,0, 0,0,0);
        tick(0,0,1,0,0,8'h41, S_RUN,0,0, 0,0,0);
        tick(0,0,0,0,0,8'h41, S_HALT,0,0, 0,0,0);
`endif

        // Asynchronous reset in the middle of RUN.
        tick(1,0,0,0,0,8'h50, S_HALT,0,0, 0,0,0);
        tick(0,0,0,0,0,8'h50, S_RUN,1,0, 0,0,0);
        check("pre_arst_pc_en", 32'(pc_en), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'(S_INIT));
        check("arst_pc_en", 32'(pc_en), 0);
        check("arst_instr", 32'(instr_cnt), 0);
        check("arst_cycle", 32'(cycle_cnt), 0);
        @(negedge clk); #1;
        check("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
